// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream in_* side and downstream out_* side.
// "slave" is the stage's view; "master" is the view of whoever drives and sinks it.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a 2-entry skid buffer, flush and stall support.
// Optional stall performance counter enabled by defining PIPE_STAGE_PERF_EN.
//
// Handshake: a beat moves upstream->stage when in_valid && in_ready at a rising edge,
// and stage->downstream when out_valid && out_ready; in_ready is registered and depends
// only on occupancy, so the skid entry absorbs the beat that arrives as the stage fills.
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    pipe_stage_reg_if.slave   bus,
    input  logic              flush,
    output logic [31:0]       stall_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic accept;
    logic drain;
    logic load_main_in;
    logic load_skid_in;
    logic move_skid;

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        load_main_in = 1'b0;
        load_skid_in = 1'b0;
        move_skid    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid_in = 1'b1;
                        state_d      = TWO;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        move_skid = 1'b1;
                        state_d   = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data   <= '0;
            main_ctrl   <= '0;
            skid_data   <= '0;
            skid_ctrl   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            if (load_main_in) begin
                main_data <= bus.in_data;
                main_ctrl <= bus.in_ctrl;
            end else if (move_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid_in) begin
                skid_data <= bus.in_data;
                skid_ctrl <= bus.in_ctrl;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data;
    // Gate control so a stale write enable never leaks out of an empty stage.
    assign bus.out_ctrl  = out_valid_q ? main_ctrl : '0;
    assign dbg_state     = state_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg against a queue-based reference of the stage.
module tb_pipe_stage_reg;
    localparam int DATA_W = 69;
    localparam int CTRL_W = 2;
    localparam int W      = DATA_W + CTRL_W;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] stall_count;
    logic [1:0]  dbg_state;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .flush       (flush),
        .stall_count (stall_count),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    // Reference: the stage is a FIFO of at most two beats, {ctrl, data} per entry.
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] last_data;
    logic [31:0]       stall_exp;
    int                n_checks = 0;
    int                n_errors = 0;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic v, input logic [DATA_W-1:0] d,
                                input logic [CTRL_W-1:0] c, input logic ordy,
                                input logic fl, input logic rs);
        logic acc, dr;
        if (rs) begin
            exp_q.delete();
            last_data = '0;
            stall_exp = '0;
        end else begin
            if (PERF && exp_q.size() > 0 && !ordy && stall_exp != 32'hFFFF_FFFF)
                stall_exp = stall_exp + 32'd1;
            if (fl) begin
                exp_q.delete();
            end else begin
                acc = v && (exp_q.size() < 2);
                dr  = (exp_q.size() > 0) && ordy;
                if (dr) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({c, d});
            end
            if (exp_q.size() > 0) last_data = exp_q[0][DATA_W-1:0];
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("out_valid", 128'(bus.out_valid), 128'(exp_q.size() > 0));
        check("in_ready", 128'(bus.in_ready), 128'(exp_q.size() < 2));
        check("out_ctrl", 128'(bus.out_ctrl), 128'(head[W-1:DATA_W]));
        check("out_data", 128'(bus.out_data), 128'(last_data));
        check("stall_count", 128'(stall_count), 128'(stall_exp));
    endtask

    // Drive inputs between edges, advance one clock, update model, check #1 after the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic ordy, input logic fl, input logic rs);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.out_ready = ordy;
        flush         = fl;
        reset         = rs;
        @(posedge clock);
        model_update(v, d, c, ordy, fl, rs);
        #1;
        check_outputs();
    endtask

    logic [DATA_W-1:0] p2;
    int                idx;
    int                seq_exp;
    int                budget;
    logic              v_r, rdy_r;

    initial begin
        exp_q.delete();
        last_data = '0;
        stall_exp = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 0;
        flush = 0; reset = 1;

        // Reset then idle
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 0);
        check("t1_out_valid", 128'(bus.out_valid), 128'(0));
        check("t1_out_data", 128'(bus.out_data), 128'(0));
        check("t1_in_ready", 128'(bus.in_ready), 128'(1));

        // Single beat pass-through
        p2 = {32'd1234, 32'd12345, 5'd31};
        step(1, p2, 2'b11, 1, 0, 0);
        check("t2_data", 128'(bus.out_data), 128'(p2));
        check("t2_ctrl", 128'(bus.out_ctrl), 128'(2'b11));
        step(0, '0, '0, 1, 0, 0);
        check("t2_valid_after", 128'(bus.out_valid), 128'(0));
        check("t2_ctrl_after", 128'(bus.out_ctrl), 128'(0));

        // Fill to two entries, then drain in order
        step(1, 69'd1, 2'b01, 0, 0, 0);
        step(1, 69'd2, 2'b10, 0, 0, 0);
        check("t3_state", 128'(dbg_state), 128'(2));
        check("t3_in_ready", 128'(bus.in_ready), 128'(0));
        check("t3_hold_a", 128'(bus.out_data), 128'(1));
        step(0, '0, '0, 0, 0, 0);
        check("t3_stable_a", 128'(bus.out_data), 128'(1));
        step(0, '0, '0, 1, 0, 0);
        check("t3_b", 128'(bus.out_data), 128'(2));
        check("t3_ready_back", 128'(bus.in_ready), 128'(1));
        step(0, '0, '0, 1, 0, 0);
        check("t3_empty", 128'(bus.out_valid), 128'(0));

        // Random stream of 100 numbered beats
        idx = 0; seq_exp = 0; budget = 0;
        while (idx < 100 && budget < 3000) begin
            v_r   = 1'($urandom_range(0, 1));
            rdy_r = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && rdy_r) begin
                check("t4_order", 128'(bus.out_data), 128'(seq_exp));
                seq_exp++;
            end
            if (v_r && exp_q.size() < 2) begin
                step(1, DATA_W'(idx), CTRL_W'(idx), rdy_r, 0, 0);
                idx++;
            end else begin
                step(v_r, DATA_W'(idx), CTRL_W'(idx), rdy_r, 0, 0);
            end
            budget++;
        end
        check("t4_all_sent", 128'(idx), 128'(100));
        budget = 0;
        while (seq_exp < 100 && budget < 10) begin
            if (bus.out_valid) begin
                check("t4_order", 128'(bus.out_data), 128'(seq_exp));
                seq_exp++;
            end
            step(0, '0, '0, 1, 0, 0);
            budget++;
        end
        check("t4_count", 128'(seq_exp), 128'(100));

        // Flush from TWO with a beat presented the same cycle
        step(1, 69'd10, 2'b11, 0, 0, 0);
        step(1, 69'd11, 2'b11, 0, 0, 0);
        step(1, 69'd7, 2'b11, 0, 1, 0);
        check("t5_valid", 128'(bus.out_valid), 128'(0));
        check("t5_ctrl", 128'(bus.out_ctrl), 128'(0));
        check("t5_ready", 128'(bus.in_ready), 128'(1));
        for (int i = 0; i < 3; i++) begin
            step(0, '0, '0, 1, 0, 0);
            check("t5_no_seven", 128'(bus.out_valid), 128'(0));
        end

        // Stall counter
        step(0, '0, '0, 0, 0, 1);
        step(1, 69'd5, 2'b01, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, '0, '0, 0, 0, 0);
        check("t6_stall10", 128'(stall_count), 128'(PERF ? 10 : 0));
        step(0, '0, '0, 1, 1, 0);
        check("t6_after_flush", 128'(stall_count), 128'(PERF ? 10 : 0));
        step(0, '0, '0, 0, 0, 1);
        check("t6_after_reset", 128'(stall_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces fixed per-stage registers such as the MEM/WB register. It carries a data payload and a control payload across a valid/ready handshake. It contains a 2-entry skid buffer, so a registered in_ready never drops a beat. Adds flush (bubble insertion) and stall support that the fixed-width stage registers lack.

Parameters:
DATA_W, 69, payload data width in bits (default fits read_data 32 + ALU_result 32 + rd 5)
CTRL_W, 2, control payload width in bits (default fits WB_reg_write, WB_mem_to_reg)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept; registered, depends only on state
in_data  input  DATA_W  upstream data payload
in_ctrl  input  CTRL_W  upstream control payload
out_valid  output  1  beat present at output
out_ready  input  1  downstream accepts
out_data  output  DATA_W  data payload of head beat
out_ctrl  output  CTRL_W  control of head beat; forced to 0 when out_valid=0
flush  input  1  discard all held beats (branch mispredict / exception)
stall_count  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (synchronous, sampled on rising edge with reset=1): state EMPTY; out_valid=0; out_data=0; out_ctrl=0; in_ready=1; skid contents=0; stall_count=0. Reset overrides flush and all handshakes.
- Storage: main register (drives outputs) plus skid register.
- States: EMPTY (none held), ONE (main held), TWO (main + skid held).
- in_ready = 1 in EMPTY and ONE; 0 in TWO.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- EMPTY: accept -> load main, go ONE. Otherwise stay.
- ONE, accept && drain: load main with new beat, stay ONE.
- ONE, accept only: load skid, go TWO.
- ONE, drain only: go EMPTY.
- ONE, neither: hold.
- TWO, drain: move skid to main, go ONE. No accept is possible in TWO.
- TWO, no drain: hold.
- Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle) when the stage was EMPTY, or when ONE with a simultaneous drain.
- Ordering: strict FIFO; beats are never dropped or duplicated except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_ctrl hold their values.
- out_ctrl is gated to 0 whenever out_valid=0, so downstream never sees a spurious write enable.
- Flush (sampled at edge, priority over accept and drain):
  - go EMPTY; out_valid=0; out_ctrl=0.
  - out_data keeps its last value (don't-care).
  - A beat presented in the same cycle as flush is discarded.
  - in_ready=1 in the following cycle.
- Reset mid-operation: held beats are discarded exactly as for flush, and all registers are zeroed.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: stall_count increments by 1 every cycle with out_valid=1 and out_ready=0. Saturates at 32'hFFFF_FFFF. Cleared only by reset; flush does not clear it.
- Undefined: stall_count is tied to 32'd0 and no counter logic is built.
- The port exists in both builds.

Test Plan:
1. Reset for 1 cycle, then idle -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
2. Send in_data={32'd1234, 32'd12345, 5'd31}, in_ctrl=2'b11, out_ready=1 -> one cycle later out_valid=1 with identical payload; next cycle out_valid=0 and out_ctrl=2'b00.
3. Hold out_ready=0 and send beats A=1, B=2 -> state TWO, in_ready=0, out_data stays A. Raise out_ready -> A then B on consecutive cycles, in_ready=1 after A drains.
4. Stream 100 beats (data=i, ctrl=i[1:0]) with random in_valid and out_ready -> output sequence exactly 0..99 in order, no loss or duplication.
5. In TWO, assert flush together with in_valid=1 (data=7) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; beat 7 never appears at the output.
6. With PIPE_STAGE_PERF_EN defined, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_count=10; assert flush -> stays 10; assert reset -> 0. Without the macro, stall_count reads 0 throughout.
